noise_bias_ctrl: RTL
====================

NOISE_BIAS_CTRL -- requirements
Module: noise_bias_ctrl

Interface
REQ-001 Parameters: VW=8 voltage width; WIN_LEN=1000 window length (clk cycles); NOISE_THR=4 noise edges that make a window noisy; WIN_NEED=3 consecutive noisy windows that trigger back-off; HOLD_WIN=4 quiet windows to leave HOLD; STEP_UP=1; STEP_DOWN=8; V_MIN=0; V_START=16; V_MAX=200.
REQ-002 The block SHALL have one clock and a synchronous active-high reset, with ports: clk in 1 rising-edge clock; reset in 1 synchronous active-high reset.
REQ-003 Ports SHALL be: start in 1 run request pulse; noise_valid in 1 asynchronous noise indicator; spi_busy in 1 DAC link busy; voltage out VW bias code; spi_start out 1 DAC write pulse; varu out 1 back-off active; fault out 1 no headroom; debug_window_count out NW consecutive noisy windows, NW=$clog2(WIN_NEED+1); debug_state out 3 FSM state.

Function
REQ-004 noise_valid SHALL pass a 2-flop synchronizer and then a rising-edge detector; an edge is one cycle of noise_edge; pulses shorter than one clk period MAY be missed.
REQ-005 The FSM SHALL have states IDLE=0, RAMP=1, HOLD=2, FAULT=3, encoded on debug_state.
REQ-006 In IDLE or FAULT, start=1 SHALL load voltage=V_START, clear window/noise/noisy counters and fault, and enter RAMP on the next cycle; start in RAMP/HOLD SHALL be ignored.
REQ-007 In RAMP/HOLD, a window counter SHALL count 0..WIN_LEN-1 and wrap; the cycle at WIN_LEN-1 is window end.
REQ-008 A noise counter SHALL count noise_edge, saturate at NOISE_THR, and clear at window end; an edge on the window-end cycle counts toward the ending window.
REQ-009 A window SHALL be noisy if its final count (including any same-cycle edge) equals NOISE_THR.
REQ-010 RAMP, quiet window end: noisy count cleared, voltage=min(V_MAX, voltage+STEP_UP), computed in VW+1 bits.
REQ-011 RAMP, noisy window end with noisy count+1 < WIN_NEED: noisy count incremented, voltage unchanged.
REQ-012 RAMP, noisy window end with noisy count+1 = WIN_NEED: back-off occurs, noisy count cleared.
REQ-013 Back-off with voltage > V_MIN SHALL set voltage=max(V_MIN, voltage-STEP_DOWN), clear the hold counter, and enter or remain in HOLD.
REQ-014 Back-off with voltage = V_MIN SHALL enter FAULT, leave voltage unchanged, and set fault=1.
REQ-015 HOLD, noisy window end: immediate back-off per REQ-013/014, no WIN_NEED qualification.
REQ-016 HOLD, quiet window end: hold counter incremented; at HOLD_WIN, return to RAMP with voltage unchanged and the hold counter cleared.
REQ-017 varu SHALL be 1 exactly while state=HOLD; fault SHALL be 1 exactly while state=FAULT.
REQ-018 Every cycle in which the voltage register changes value SHALL set a pending flag; a clamp that leaves the value unchanged SHALL NOT set it.
REQ-019 spi_start SHALL be a one-cycle pulse on any cycle with pending=1 and spi_busy=0, clearing pending; changes made while pending SHALL merge into one pulse; spi_start SHALL follow the registered voltage by 1 cycle minimum.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 On reset=1 at a clk edge: state=IDLE, voltage=V_MIN, spi_start=0, varu=0, fault=0, pending=0, all counters=0, synchronizer flops=0; reset SHALL override start and every in-progress window, back-off or pending write.

Verification (WIN_LEN=16, other defaults unless stated)
REQ-022 Reset, start pulse, no noise for 10 windows -> voltage 16 then 17..26, one spi_start per step, varu=0, debug_state=1.
REQ-023 After REQ-022, 4 edges per window for 3 windows -> debug_window_count 1,2 then 0; voltage 26->18 at third window end; varu=1, state=2; 4 quiet windows -> state=1, next quiet window 19.
REQ-024 V_MAX=20, quiet run -> voltage saturates at 20; no spi_start after reaching 20.
REQ-025 V_START=4: 3 noisy windows -> voltage 0 in HOLD; next noisy window -> FAULT, fault=1, varu=0, voltage 0; start -> voltage 4, RAMP, fault=0.
REQ-026 spi_busy held high across 3 voltage steps -> no spi_start; spi_busy low -> exactly one spi_start next cycle with final voltage; 3 edges then edge on window-end cycle counts noisy; reset mid-HOLD -> all REQ-021 values next cycle.

Source files
------------

// File: rtl/noise_bias_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : noise_bias_ctrl
// Description : Closed-loop bias voltage controller. Slowly ramps a bias code
//               while the detector is quiet. It backs the bias off when noise
//               edges persist over consecutive observation windows, and
//               requests a DAC write whenever the code changes.
//
// Ports       : clk                - rising-edge clock
//               reset              - synchronous active-high reset
//               start              - run request pulse (honoured in IDLE/FAULT)
//               noise_valid        - asynchronous noise indicator
//               spi_busy           - DAC link busy, defers spi_start
//               voltage            - bias code (VW bits)
//               spi_start          - one-cycle DAC write request
//               varu               - high while backed off (HOLD)
//               fault              - high while out of headroom (FAULT)
//               debug_window_count - consecutive noisy windows seen in RAMP
//               debug_state        - FSM state (0 IDLE, 1 RAMP, 2 HOLD, 3 FAULT)
//
// Revision    : 1.0 - initial release
// ============================================================================
module noise_bias_ctrl #(
    parameter int VW        = 8,
    parameter int WIN_LEN   = 1000,
    parameter int NOISE_THR = 4,
    parameter int WIN_NEED  = 3,
    parameter int HOLD_WIN  = 4,
    parameter int STEP_UP   = 1,
    parameter int STEP_DOWN = 8,
    parameter int V_MIN     = 0,
    parameter int V_START   = 16,
    parameter int V_MAX     = 200,
    parameter int NW        = $clog2(WIN_NEED + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          noise_valid,
    input  logic          spi_busy,
    output logic [VW-1:0] voltage,
    output logic          spi_start,
    output logic          varu,
    output logic          fault,
    output logic [NW-1:0] debug_window_count,
    output logic [2:0]    debug_state
);

    localparam int c_win_w   = $clog2(WIN_LEN);
    localparam int c_noise_w = $clog2(NOISE_THR + 1);
    localparam int c_hold_w  = $clog2(HOLD_WIN + 1);
    localparam int c_vw1     = VW + 1;

    localparam logic [VW-1:0] c_v_min   = VW'(V_MIN);
    localparam logic [VW-1:0] c_v_max   = VW'(V_MAX);
    localparam logic [VW-1:0] c_v_start = VW'(V_START);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_FAULT = 3'd3
    } state_t;

    state_t                 r_state;
    logic [VW-1:0]          r_voltage;
    logic                   r_spi_start;
    logic                   r_varu;
    logic                   r_fault;
    logic                   r_pending;
    logic [c_win_w-1:0]     r_win;
    logic [c_noise_w-1:0]   r_noise;
    logic [NW-1:0]          r_noisy_cnt;
    logic [c_hold_w-1:0]    r_hold;
    logic [1:0]             r_sync;
    logic                   r_sync_q;

    logic                   w_noise_edge;
    logic                   w_active;
    logic                   w_win_end;
    logic [c_noise_w-1:0]   w_noise_final;
    logic                   w_noisy;
    logic                   w_start_ok;
    logic                   w_ramp_up;
    logic                   w_need_met;
    logic                   w_backoff;
    logic                   w_has_room;
    logic [VW:0]            w_up_sum;
    logic [VW-1:0]          w_vol_up;
    logic [VW-1:0]          w_vol_down;
    logic [VW-1:0]          w_voltage_nxt;
    logic                   w_spi_issue;

    // Rising edge of the synchronized noise indicator.
    assign w_noise_edge = r_sync[1] & ~r_sync_q;

    assign w_active  = (r_state == ST_RAMP) || (r_state == ST_HOLD);
    assign w_win_end = w_active && (r_win == c_win_w'(WIN_LEN - 1));

    // Count including this cycle's edge, so an edge on the window-end cycle
    // still belongs to the window that is closing.
    assign w_noise_final = (r_noise == c_noise_w'(NOISE_THR)) ? r_noise
                         : r_noise + c_noise_w'(w_noise_edge);
    assign w_noisy       = (w_noise_final == c_noise_w'(NOISE_THR));

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_FAULT));
    assign w_ramp_up  = w_win_end && (r_state == ST_RAMP) && !w_noisy;
    assign w_need_met = (r_noisy_cnt == NW'(WIN_NEED - 1));
    // HOLD backs off on any noisy window; RAMP needs WIN_NEED in a row.
    assign w_backoff  = w_win_end && w_noisy &&
                        ((r_state == ST_HOLD) || ((r_state == ST_RAMP) && w_need_met));
    assign w_has_room = (r_voltage > c_v_min);

    // One extra bit so the step cannot wrap before the ceiling clamp.
    assign w_up_sum   = {1'b0, r_voltage} + c_vw1'(STEP_UP);
    assign w_vol_up   = (w_up_sum > c_vw1'(V_MAX)) ? c_v_max : w_up_sum[VW-1:0];
    assign w_vol_down = ({1'b0, r_voltage} >= c_vw1'(V_MIN + STEP_DOWN))
                      ? r_voltage - VW'(STEP_DOWN) : c_v_min;

    always_comb begin
        w_voltage_nxt = r_voltage;
        if (w_start_ok) begin
            w_voltage_nxt = c_v_start;
        end else if (w_ramp_up) begin
            w_voltage_nxt = w_vol_up;
        end else if (w_backoff && w_has_room) begin
            w_voltage_nxt = w_vol_down;
        end
    end

    assign w_spi_issue = r_pending & ~spi_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_voltage   <= c_v_min;
            r_spi_start <= 1'b0;
            r_varu      <= 1'b0;
            r_fault     <= 1'b0;
            r_pending   <= 1'b0;
            r_win       <= '0;
            r_noise     <= '0;
            r_noisy_cnt <= '0;
            r_hold      <= '0;
            r_sync      <= '0;
            r_sync_q    <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], noise_valid};
            r_sync_q    <= r_sync[1];
            r_voltage   <= w_voltage_nxt;
            r_spi_start <= w_spi_issue;
            // A change landing in the same cycle as a write keeps pending set,
            // so the DAC always ends up with the latest code. A clamp that
            // leaves the code unchanged requests nothing.
            r_pending   <= (w_voltage_nxt != r_voltage) | (r_pending & spi_busy);

            case (r_state)
                ST_IDLE, ST_FAULT: begin
                    if (start) begin
                        r_win       <= '0;
                        r_noise     <= '0;
                        r_noisy_cnt <= '0;
                        r_hold      <= '0;
                        r_state     <= ST_RAMP;
                        r_varu      <= 1'b0;
                        r_fault     <= 1'b0;
                    end
                end
                ST_RAMP, ST_HOLD: begin
                    r_win   <= w_win_end ? '0 : r_win + c_win_w'(1);
                    r_noise <= w_win_end ? '0 : w_noise_final;
                    if (w_win_end) begin
                        if (w_backoff) begin
                            r_noisy_cnt <= '0;
                            if (w_has_room) begin
                                r_state <= ST_HOLD;
                                r_hold  <= '0;
                                r_varu  <= 1'b1;
                                r_fault <= 1'b0;
                            end else begin
                                r_state <= ST_FAULT;
                                r_varu  <= 1'b0;
                                r_fault <= 1'b1;
                            end
                        end else if (r_state == ST_RAMP) begin
                            r_noisy_cnt <= w_noisy ? r_noisy_cnt + NW'(1) : '0;
                        end else if (r_hold == c_hold_w'(HOLD_WIN - 1)) begin
                            // Enough quiet windows in HOLD: resume ramping.
                            r_hold  <= '0;
                            r_state <= ST_RAMP;
                            r_varu  <= 1'b0;
                        end else begin
                            r_hold <= r_hold + c_hold_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_varu  <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    assign voltage            = r_voltage;
    assign spi_start          = r_spi_start;
    assign varu               = r_varu;
    assign fault              = r_fault;
    assign debug_window_count = r_noisy_cnt;
    assign debug_state        = r_state;

endmodule
`default_nettype wire
